// File: rtl/key_cond.sv
// Three-key push-button conditioner: synchronize, debounce, then emit one-cycle press pulses with optional auto-repeat.
// Pulse and level appear together DEB_CYCLES+2 edges after a steady low is first sampled; no backpressure.
module key_cond #(
  parameter int         DEB_CYCLES   = 1000000,
  parameter int         REPEAT_DELAY = 25000000,
  parameter int         REPEAT_RATE  = 5000000,
  parameter logic [2:0] REPEAT_MASK  = 3'b011
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] key_n,
  output logic [2:0] press,
  output logic [2:0] level,
  output logic       any_press
);

  localparam int DW     = $clog2(DEB_CYCLES + 1);
  localparam int RMAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW     = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DEB_TC   = DW'(DEB_CYCLES);
  localparam logic [RW-1:0] DELAY_TC = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_TC  = RW'(REPEAT_RATE - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HELD   = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  logic [2:0] w_pulse;
  logic       r_any;

  for (genvar i = 0; i < 3; i++) begin : g_key
    logic          r_sync1;
    logic          r_sync2;
    logic [DW-1:0] r_deb_cnt;
    logic          r_level;
    logic [1:0]    r_state;
    logic [RW-1:0] r_rep_cnt;
    logic          r_press;

    logic          w_diff;
    logic          w_toggle;
    logic          w_rise;
    logic          w_fall;
    logic [1:0]    w_state_nxt;
    logic [RW-1:0] w_rep_nxt;
    logic          w_pulse_k;

    // r_sync2 is still active-low; compare its pressed sense against the accepted level
    assign w_diff   = (~r_sync2) != r_level;
    assign w_toggle = w_diff && (r_deb_cnt == DEB_TC);
    assign w_rise   = w_toggle && !r_level;
    assign w_fall   = w_toggle && r_level;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sync1   <= 1'b1;
        r_sync2   <= 1'b1;
        r_deb_cnt <= '0;
        r_level   <= 1'b0;
      end else begin
        r_sync1 <= key_n[i];
        r_sync2 <= r_sync1;
        if (!w_diff || w_toggle) begin
          r_deb_cnt <= '0;
        end else begin
          r_deb_cnt <= r_deb_cnt + 1'b1;
        end
        if (w_toggle) begin
          r_level <= ~r_level;
        end
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_rep_nxt   = r_rep_cnt;
      w_pulse_k   = 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            w_state_nxt = S_HELD;
            w_rep_nxt   = '0;
            w_pulse_k   = 1'b1;
          end
        end
        S_HELD: begin
          if (w_fall) begin
            w_state_nxt = S_IDLE;
            w_rep_nxt   = '0;
          end else if (r_rep_cnt == DELAY_TC) begin
            // single-shot keys park at terminal count until release
            if (REPEAT_MASK[i]) begin
              w_state_nxt = S_REPEAT;
              w_rep_nxt   = '0;
              w_pulse_k   = 1'b1;
            end
          end else begin
            w_rep_nxt = r_rep_cnt + 1'b1;
          end
        end
        S_REPEAT: begin
          if (w_fall) begin
            w_state_nxt = S_IDLE;
            w_rep_nxt   = '0;
          end else if (r_rep_cnt == RATE_TC) begin
            w_rep_nxt = '0;
            w_pulse_k = 1'b1;
          end else begin
            w_rep_nxt = r_rep_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_rep_nxt   = '0;
        end
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state   <= S_IDLE;
        r_rep_cnt <= '0;
        r_press   <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_rep_cnt <= w_rep_nxt;
        r_press   <= w_pulse_k;
      end
    end

    assign w_pulse[i] = w_pulse_k;
    assign press[i]   = r_press;
    assign level[i]   = r_level;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_any <= 1'b0;
    end else begin
      r_any <= |w_pulse;
    end
  end

  assign any_press = r_any;

endmodule

// File: tb/tb_key_cond.sv
// Bench for key_cond: directed and random key waveforms against a sample-window reference model with a scoreboard.
module tb_key_cond;
  localparam int         DEB  = 4;
  localparam int         RD   = 20;
  localparam int         RR   = 8;
  localparam logic [2:0] MASK = 3'b011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] key_n = 3'b111;
  logic [2:0] press;
  logic [2:0] level;
  logic       any_press;

  key_cond #(
    .DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .REPEAT_MASK(MASK)
  ) dut (
    .clk(clk), .rst(rst), .key_n(key_n),
    .press(press), .level(level), .any_press(any_press)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  bit   started = 0;
  bit   done = 0;
  logic [6:0] exp_q[$];

  // Reference model: raw samples per key, newest at the highest index.
  bit         hist[3][DEB+3];
  logic [2:0] m_level;
  int         m_since[3];
  int         edge_no = 0;

  function automatic void model_edge(input bit r, input logic [2:0] kn);
    logic [2:0] p;
    bit all_low, all_high;
    int age;
    p = '0;
    edge_no++;
    if (r) begin
      for (int k = 0; k < 3; k++)
        for (int j = 0; j < DEB + 3; j++) hist[k][j] = 1'b1;
      m_level = '0;
      exp_q.push_back(7'b0);
      return;
    end
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < DEB + 2; j++) hist[k][j] = hist[k][j+1];
      hist[k][DEB+2] = kn[k];
      // a change is accepted once the samples from edges e-2-DEB .. e-2 all agree
      all_low = 1'b1;
      all_high = 1'b1;
      for (int j = 0; j <= DEB; j++) begin
        if (hist[k][j]) all_low = 1'b0;
        else            all_high = 1'b0;
      end
      if (!m_level[k] && all_low) begin
        m_level[k] = 1'b1;
        m_since[k] = edge_no;
        p[k] = 1'b1;
      end else if (m_level[k] && all_high) begin
        m_level[k] = 1'b0;
      end else if (m_level[k] && MASK[k]) begin
        age = edge_no - m_since[k];
        if (age >= RD && ((age - RD) % RR) == 0) p[k] = 1'b1;
      end
    end
    exp_q.push_back({p, m_level, |p});
  endfunction

  task automatic step(input bit r, input logic [2:0] kn);
    @(negedge clk);
    rst = r;
    key_n = kn;
    started = 1'b1;
    @(posedge clk);
    model_edge(r, kn);
  endtask

  task automatic hold(input bit r, input logic [2:0] kn, input int n);
    for (int c = 0; c < n; c++) step(r, kn);
  endtask

  // Monitor: every edge presents a response; compare it with the oldest expectation.
  initial begin : monitor
    logic [6:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (done) break;
      if (!started) continue;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow t=%0t got press=%b level=%b any=%b required an expectation", $time, press, level, any_press);
        continue;
      end
      e = exp_q.pop_front();
      if (press !== e[6:4]) begin
        errors++;
        $display("FAIL press t=%0t got %b required %b", $time, press, e[6:4]);
      end
      checks++;
      if (level !== e[3:1]) begin
        errors++;
        $display("FAIL level t=%0t got %b required %b", $time, level, e[3:1]);
      end
      checks++;
      if (any_press !== e[0]) begin
        errors++;
        $display("FAIL any_press t=%0t got %b required %b", $time, any_press, e[0]);
      end
    end
  end

  initial begin : stimulus
    int         rem[3];
    logic [2:0] kv;
    bit         r;
    for (int k = 0; k < 3; k++) m_since[k] = 0;
    m_level = '0;
    hold(1'b1, 3'b111, 4);
    hold(1'b0, 3'b111, 6);
    // up and down pressed together, held through several repeats
    hold(1'b0, 3'b100, 70);
    hold(1'b0, 3'b111, 15);
    // down bounces with glitches shorter than the debounce window, then settles low
    for (int b = 0; b < 5; b++) begin
      hold(1'b0, 3'b101, 3);
      hold(1'b0, 3'b111, 1);
    end
    hold(1'b0, 3'b101, 40);
    hold(1'b0, 3'b111, 15);
    // mode held long: single shot only
    hold(1'b0, 3'b011, 100);
    hold(1'b0, 3'b111, 15);
    // reset while up is repeating, key still held afterwards
    hold(1'b0, 3'b110, 40);
    hold(1'b1, 3'b110, 5);
    hold(1'b0, 3'b110, 40);
    hold(1'b0, 3'b111, 15);
    // random bouncing, holds and occasional resets
    for (int k = 0; k < 3; k++) rem[k] = 0;
    kv = 3'b111;
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (rem[k] == 0) begin
          kv[k] = 1'($urandom_range(0, 1));
          rem[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 70))
                                               : int'($urandom_range(1, DEB + 2));
        end
        rem[k]--;
      end
      r = ($urandom_range(0, 299) == 0);
      step(r, kv);
    end
    hold(1'b0, 3'b111, 12);
    @(negedge clk);
    done = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d leftover required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog timeout got no completion required finish");
    $fatal(1, "timeout");
  end
endmodule
